gray_codec_pipe: RTL and testbench

GRAY_CODEC_PIPE -- requirements
Module: gray_codec_pipe

---
 rtl/gray_codec_pipe.sv | 140 ++++++++++++++
 tb/tb_gray_codec_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/gray_codec_pipe.sv
// gray_codec_pipe -- two-stage valid/ready pipeline that converts words
// between binary and Gray code, or emits a free-running Gray counter.
//
// Stage 1 holds the accepted word and its mode. Stage 2 holds the converted
// result that drives data_o.
//
// Ports
//   clk_i        clock, all state changes on the rising edge
//   rst_i        synchronous active-high reset
//   mode_i       00 passthrough, 01 bin->Gray, 10 Gray->bin, 11 Gray counter
//   data_i       input word (ignored in mode 11)
//   in_valid_i   upstream offers a beat
//   in_ready_o   block can accept a beat this cycle
//   data_o       converted word
//   out_valid_o  data_o holds a beat
//   out_ready_i  downstream accepts the beat on data_o
//   parity_o     XOR of data_o bits (only with GRAY_CODEC_PIPE_PARITY_EN)
//
// Optional feature macro: GRAY_CODEC_PIPE_PARITY_EN adds the registered
// parity_o output. Without it the port and its register do not exist.
module gray_codec_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  output logic [WIDTH-1:0] data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
`ifdef GRAY_CODEC_PIPE_PARITY_EN
  ,
  output logic             parity_o
`endif
);

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_B2G  = 2'b01;
  localparam logic [1:0] MODE_G2B  = 2'b10;
  localparam logic [1:0] MODE_GCNT = 2'b11;

  function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it, so the
  // result is built from the MSB downwards.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b = '0;
    b[WIDTH-1] = g[WIDTH-1];
    for (int k = WIDTH - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  logic             v1;
  logic [1:0]       m1;
  logic [WIDTH-1:0] d1;
  logic             v2;
  logic [WIDTH-1:0] d2;
  logic [WIDTH-1:0] cnt;
  logic             ready2;
  logic             accept;
  logic [WIDTH-1:0] conv;

  // Stage 2 can take a new word when empty or when its word leaves this
  // cycle; stage 1 can take one when empty or when it moves into stage 2.
  assign ready2      = !v2 || out_ready_i;
  assign in_ready_o  = !v1 || ready2;
  assign accept      = in_valid_i && in_ready_o;
  assign data_o      = d2;
  assign out_valid_o = v2;

  // Conversion of the stage-1 word. In counter mode stage 1 already holds
  // the sampled binary counter value, so it only needs Gray encoding.
  always_comb begin
    conv = d1;
    case (m1)
      MODE_PASS: conv = d1;
      MODE_B2G:  conv = bin_to_gray(d1);
      MODE_G2B:  conv = gray_to_bin(d1);
      MODE_GCNT: conv = bin_to_gray(d1);
      default:   conv = d1;
    endcase
  end

  // Pipeline registers and the Gray counter. The counter is captured into
  // stage 1 at acceptance, so mode and counter value travel with the beat
  // and stalled offers never advance it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v1  <= 1'b0;
      m1  <= MODE_PASS;
      d1  <= '0;
      v2  <= 1'b0;
      d2  <= '0;
      cnt <= '0;
    end else begin
      if (in_ready_o) begin
        v1 <= in_valid_i;
      end
      if (accept) begin
        m1 <= mode_i;
        if (mode_i == MODE_GCNT) begin
          d1  <= cnt;
          cnt <= cnt + WIDTH'(1);
        end else begin
          d1 <= data_i;
        end
      end
      if (ready2) begin
        v2 <= v1;
        if (v1) begin
          d2 <= conv;
        end
      end
    end
  end

`ifdef GRAY_CODEC_PIPE_PARITY_EN
  logic p2;

  assign parity_o = p2;

  // Parity is registered alongside the stage-2 word so it obeys the same
  // stall and reset behaviour as data_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p2 <= 1'b0;
    end else if (ready2 && v1) begin
      p2 <= ^conv;
    end
  end
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
// tb_gray_codec_pipe -- directed self-checking bench for gray_codec_pipe
// with WIDTH=8. A table of single-beat conversions is followed by
// hand-written sequences for the counter, stall, wrap and reset cases.
module tb_gray_codec_pipe;

  localparam int WIDTH = 8;

  logic             clk_i;
  logic             rst_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] data_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] data_o;
  logic             out_valid_o;
  logic             out_ready_i;
`ifdef GRAY_CODEC_PIPE_PARITY_EN
  logic             parity_o;
`endif

  int checks;
  int errors;

  typedef struct {
    logic [1:0]       mode;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] expected;
    string            name;
  } vec_t;

  vec_t vectors [10];

  gray_codec_pipe #(.WIDTH(WIDTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .mode_i      (mode_i),
    .data_i      (data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .data_o      (data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
`ifdef GRAY_CODEC_PIPE_PARITY_EN
    ,
    .parity_o    (parity_o)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [7:0] gray8(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] mode,
                               input logic [WIDTH-1:0] data, input logic ready);
    in_valid_i  = valid;
    mode_i      = mode;
    data_i      = data;
    out_ready_i = ready;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One isolated beat: accept, check it is still in stage 1, then check the
  // converted word one edge later and that the pipe drains afterwards.
  task automatic sendOne(input logic [1:0] mode, input logic [WIDTH-1:0] data,
                         input logic [WIDTH-1:0] expected, input string name);
    applyStimulus(1'b1, mode, data, 1'b1);
    checkOutput({name, "_in_ready"}, 32'(in_ready_o), 32'd1);
    step();
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
    checkOutput({name, "_not_early"}, 32'(out_valid_o), 32'd0);
    step();
    checkOutput({name, "_valid"}, 32'(out_valid_o), 32'd1);
    checkOutput({name, "_data"}, 32'(data_o), 32'(expected));
`ifdef GRAY_CODEC_PIPE_PARITY_EN
    checkOutput({name, "_parity"}, 32'(parity_o), 32'(^expected));
`endif
    step();
    checkOutput({name, "_drained"}, 32'(out_valid_o), 32'd0);
  endtask

  // Back-to-back mode-11 beats with out_ready_i held high; every cycle after
  // the first must deliver the next counter value with no bubble.
  task automatic streamGray(input int n, input logic [7:0] start,
                            output logic wrap_seen);
    logic [7:0] prev;
    logic [7:0] expected;
    wrap_seen = 1'b0;
    prev = 8'h00;
    applyStimulus(1'b1, 2'b11, 8'h5A, 1'b1);
    for (int i = 0; i <= n; i++) begin
      if (i == n) applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
      step();
      if (i >= 1) begin
        expected = gray8(start + 8'(i - 1));
        checkOutput($sformatf("stream_valid_%0d", i - 1), 32'(out_valid_o), 32'd1);
        checkOutput($sformatf("stream_data_%0d", i - 1), 32'(data_o), 32'(expected));
        if (i >= 2 && prev == 8'h80 && data_o == 8'h00) wrap_seen = 1'b1;
        prev = data_o;
      end
    end
    step();
    checkOutput("stream_drained", 32'(out_valid_o), 32'd0);
  endtask

  initial begin
    logic wrap_seen;
    checks = 0;
    errors = 0;

    vectors[0] = '{2'b01, 8'h05, 8'h07, "b2g_05"};
    vectors[1] = '{2'b01, 8'hFF, 8'h80, "b2g_FF"};
    vectors[2] = '{2'b10, 8'h07, 8'h05, "g2b_07"};
    vectors[3] = '{2'b10, 8'h80, 8'hFF, "g2b_80"};
    vectors[4] = '{2'b00, 8'hA5, 8'hA5, "pass_A5"};
    vectors[5] = '{2'b01, 8'h00, 8'h00, "b2g_00"};
    vectors[6] = '{2'b10, 8'hFF, 8'hAA, "g2b_FF"};
    vectors[7] = '{2'b00, 8'h3C, 8'h3C, "pass_3C"};
    vectors[8] = '{2'b01, 8'h80, 8'hC0, "b2g_80"};
    vectors[9] = '{2'b10, 8'h01, 8'h01, "g2b_01"};

    // Reset state.
    rst_i = 1'b1;
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
    step();
    step();
    rst_i = 1'b0;
    checkOutput("reset_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("reset_data", 32'(data_o), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready_o), 32'd1);
`ifdef GRAY_CODEC_PIPE_PARITY_EN
    checkOutput("reset_parity", 32'(parity_o), 32'd0);
`endif

    // Table of single-beat conversions; none of these touch the counter.
    for (int i = 0; i < 10; i++) begin
      sendOne(vectors[i].mode, vectors[i].data, vectors[i].expected, vectors[i].name);
    end

    // Five back-to-back counter beats: 00 01 03 02 06. Counter ends at 5.
    streamGray(5, 8'd0, wrap_seen);

    // Mode 11 -> 01 -> 11: counter resumes at 5 (Gray 07), then 6.
    sendOne(2'b01, 8'h05, 8'h07, "mix_b2g");
    sendOne(2'b11, 8'hFF, 8'h07, "mix_cnt5");

    // Stall: out_ready_i low for four cycles with mode-11 offers. Counter
    // values 6 and 7 are accepted (Gray 05, 04); later offers are refused.
    applyStimulus(1'b1, 2'b11, 8'h00, 1'b0);
    checkOutput("stall_ready_c0", 32'(in_ready_o), 32'd1);
    step();
    step();
    checkOutput("stall_valid_c2", 32'(out_valid_o), 32'd1);
    checkOutput("stall_data_c2", 32'(data_o), 32'h05);
    checkOutput("stall_ready_c2", 32'(in_ready_o), 32'd0);
    for (int c = 3; c <= 4; c++) begin
      step();
      checkOutput($sformatf("stall_ready_c%0d", c), 32'(in_ready_o), 32'd0);
      checkOutput($sformatf("stall_valid_c%0d", c), 32'(out_valid_o), 32'd1);
      checkOutput($sformatf("stall_data_c%0d", c), 32'(data_o), 32'h05);
    end
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
    step();
    checkOutput("release_valid_1", 32'(out_valid_o), 32'd1);
    checkOutput("release_data_1", 32'(data_o), 32'h04);
    step();
    checkOutput("release_empty", 32'(out_valid_o), 32'd0);

    // Refused offers did not advance the counter: next value is 8 (Gray 0C).
    sendOne(2'b11, 8'h00, 8'h0C, "after_stall_cnt8");

    // 256 streamed beats from 9 pass through 255 (Gray 80) and wrap to 0.
    streamGray(256, 8'd9, wrap_seen);
    checkOutput("wrap_80_to_00", 32'(wrap_seen), 32'd1);

    // Reset with two beats in flight; an offer during reset is ignored.
    applyStimulus(1'b1, 2'b11, 8'h00, 1'b1);
    step();
    step();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    applyStimulus(1'b0, 2'b00, 8'h00, 1'b1);
    checkOutput("midrst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("midrst_data", 32'(data_o), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready_o), 32'd1);
`ifdef GRAY_CODEC_PIPE_PARITY_EN
    checkOutput("midrst_parity", 32'(parity_o), 32'd0);
`endif
    step();
    checkOutput("midrst_no_partial", 32'(out_valid_o), 32'd0);
    sendOne(2'b11, 8'hAA, 8'h00, "postrst_cnt0");
    sendOne(2'b11, 8'hAA, 8'h01, "postrst_cnt1");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
